frame_rx_fsm: RTL and testbench

- Receive-side frame processor: the counterpart of the frame transmit FSM on the byte-wide link.
- Accepts a GMII-style byte stream (RXD/RX_DV/RX_ER) from the PCS.
- Locates the preamble and SFD, strips the 4-byte FCS, and forwards payload bytes downstream.
- Checks CRC-32 and reports frame status (good/bad/dropped) and payload length per frame.

---
 rtl/frame_rx_fsm.sv | 218 +++++++++++++++++++++
 tb/tb_frame_rx_fsm.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_rx_fsm.sv
// frame_rx_fsm: receive-side framer for a GMII-style byte stream.
// It finds the preamble and SFD, passes payload bytes downstream and withholds
// the trailing 4-byte FCS by delaying the stream through a 4-byte delay line.
// It checks CRC-32 and reports good/bad/dropped status and the payload length.
// Optional build macro: RX_STATS_EN adds saturating good/bad frame counters.
// When the macro is undefined, GOOD_CNT and BAD_CNT are tied to 0.
module frame_rx_fsm #(
  parameter int MIN_PRE = 2,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 11
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [7:0]       RXD,
  input  logic             RX_DV,
  input  logic             RX_ER,
  output logic [7:0]       DOUT,
  output logic             DOUT_VALID,
  output logic             SOF,
  output logic             EOF,
  output logic             CRC_OK,
  output logic             CRC_ERR,
  output logic             DROPPED,
  output logic [LEN_W-1:0] FRM_LEN,
  output logic [2:0]       FRM_STATE,
  output logic [15:0]      GOOD_CNT,
  output logic [15:0]      BAD_CNT
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
    ST_CHECK    = 3'd3,
    ST_DROP     = 3'd4
  } state_t;

  localparam logic [31:0]      CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [3:0]       MIN_PRE_C   = 4'(MIN_PRE);
  localparam logic [LEN_W-1:0] MAX_LEN_C   = LEN_W'(MAX_LEN);

  state_t           state_reg;
  logic [3:0]       pre_cnt_reg;
  logic [2:0]       dl_cnt_reg;
  logic [LEN_W-1:0] len_cnt_reg;
  logic [31:0]      crc_reg;
  logic [31:0]      crc_next;
  logic [7:0]       dl_reg [4];
  logic             push_en;

  logic [7:0]       dout_reg;
  logic             dout_valid_reg;
  logic             sof_reg;
  logic             eof_reg;
  logic             crc_ok_reg;
  logic             crc_err_reg;
  logic             dropped_reg;
  logic [LEN_W-1:0] frm_len_reg;

  // Reflected CRC-32 update for one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  assign crc_next = crc32_byte(crc_reg, RXD);

  // A byte enters the delay line only while in DATA with a clean valid byte.
  // RX_ER wins over everything else, so an errored byte is never consumed.
  assign push_en = (state_reg == ST_DATA) && RX_DV && !RX_ER;

  // Delay line: newest byte at index 0; index 3 is the oldest byte once four are held.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 4; i++) dl_reg[i] <= '0;
    end else if (push_en) begin
      dl_reg[0] <= RXD;
      for (int i = 1; i < 4; i++) dl_reg[i] <= dl_reg[i-1];
    end
  end

  // Frame state machine with all status and data outputs registered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg      <= ST_IDLE;
      pre_cnt_reg    <= '0;
      dl_cnt_reg     <= '0;
      len_cnt_reg    <= '0;
      crc_reg        <= 32'hFFFFFFFF;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      sof_reg        <= 1'b0;
      eof_reg        <= 1'b0;
      crc_ok_reg     <= 1'b0;
      crc_err_reg    <= 1'b0;
      dropped_reg    <= 1'b0;
      frm_len_reg    <= '0;
    end else begin
      dout_valid_reg <= 1'b0;
      sof_reg        <= 1'b0;
      eof_reg        <= 1'b0;
      crc_ok_reg     <= 1'b0;
      crc_err_reg    <= 1'b0;
      dropped_reg    <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (RX_DV) begin
            if (RXD == 8'h55) begin
              state_reg   <= ST_PREAMBLE;
              pre_cnt_reg <= 4'd1;
            end else begin
              state_reg   <= ST_DROP;
              dropped_reg <= 1'b1;
            end
          end
        end
        ST_PREAMBLE: begin
          if (RX_ER) begin
            state_reg   <= ST_DROP;
            dropped_reg <= 1'b1;
          end else if (!RX_DV) begin
            state_reg <= ST_IDLE;
          end else if (RXD == 8'h55) begin
            if (pre_cnt_reg != 4'd15) pre_cnt_reg <= pre_cnt_reg + 4'd1;
          end else if (RXD == 8'hD5 && pre_cnt_reg >= MIN_PRE_C) begin
            state_reg   <= ST_DATA;
            crc_reg     <= 32'hFFFFFFFF;
            dl_cnt_reg  <= '0;
            len_cnt_reg <= '0;
          end else begin
            state_reg   <= ST_DROP;
            dropped_reg <= 1'b1;
          end
        end
        ST_DATA: begin
          if (RX_ER) begin
            state_reg   <= ST_DROP;
            dropped_reg <= 1'b1;
          end else if (!RX_DV) begin
            // The delay line now holds the FCS; it is discarded.
            state_reg <= ST_CHECK;
            eof_reg   <= 1'b1;
            if (dl_cnt_reg == 3'd4 && len_cnt_reg != '0 && crc_reg == CRC_RESIDUE) begin
              crc_ok_reg <= 1'b1;
            end else begin
              crc_err_reg <= 1'b1;
            end
            frm_len_reg <= (dl_cnt_reg == 3'd4) ? len_cnt_reg : '0;
          end else begin
            crc_reg <= crc_next;
            if (dl_cnt_reg != 3'd4) begin
              dl_cnt_reg <= dl_cnt_reg + 3'd1;
            end else if (len_cnt_reg == MAX_LEN_C) begin
              // Ejecting this byte would exceed the limit: abort without emitting it.
              state_reg   <= ST_DROP;
              dropped_reg <= 1'b1;
            end else begin
              dout_reg       <= dl_reg[3];
              dout_valid_reg <= 1'b1;
              sof_reg        <= (len_cnt_reg == '0);
              len_cnt_reg    <= len_cnt_reg + 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (RX_DV && RXD == 8'h55) begin
            state_reg   <= ST_PREAMBLE;
            pre_cnt_reg <= 4'd1;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (!RX_DV) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign DOUT       = dout_reg;
  assign DOUT_VALID = dout_valid_reg;
  assign SOF        = sof_reg;
  assign EOF        = eof_reg;
  assign CRC_OK     = crc_ok_reg;
  assign CRC_ERR    = crc_err_reg;
  assign DROPPED    = dropped_reg;
  assign FRM_LEN    = frm_len_reg;
  assign FRM_STATE  = state_reg;

`ifdef RX_STATS_EN
  logic [15:0] good_cnt_reg;
  logic [15:0] bad_cnt_reg;

  // Saturating frame statistics, updated the cycle after each status pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      good_cnt_reg <= '0;
      bad_cnt_reg  <= '0;
    end else begin
      if (crc_ok_reg && good_cnt_reg != 16'hFFFF) good_cnt_reg <= good_cnt_reg + 16'd1;
      if ((crc_err_reg || dropped_reg) && bad_cnt_reg != 16'hFFFF) bad_cnt_reg <= bad_cnt_reg + 16'd1;
    end
  end

  assign GOOD_CNT = good_cnt_reg;
  assign BAD_CNT  = bad_cnt_reg;
`else
  assign GOOD_CNT = '0;
  assign BAD_CNT  = '0;
`endif

endmodule

// File: tb/tb_frame_rx_fsm.sv
// tb_frame_rx_fsm: randomized and directed frames checked against a
// frame-level reference model (preamble/SFD rules, FCS stripping, CRC-32).
module tb_frame_rx_fsm;
  localparam int MIN_PRE = 2;
  localparam int MAX_LEN = 1518;
  localparam int LEN_W   = 11;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic [7:0]       RXD = 8'h00;
  logic             RX_DV = 1'b0;
  logic             RX_ER = 1'b0;
  logic [7:0]       DOUT;
  logic             DOUT_VALID;
  logic             SOF;
  logic             EOF;
  logic             CRC_OK;
  logic             CRC_ERR;
  logic             DROPPED;
  logic [LEN_W-1:0] FRM_LEN;
  logic [2:0]       FRM_STATE;
  logic [15:0]      GOOD_CNT;
  logic [15:0]      BAD_CNT;

  frame_rx_fsm #(.MIN_PRE(MIN_PRE), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .RXD(RXD), .RX_DV(RX_DV), .RX_ER(RX_ER),
    .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .SOF(SOF), .EOF(EOF),
    .CRC_OK(CRC_OK), .CRC_ERR(CRC_ERR), .DROPPED(DROPPED),
    .FRM_LEN(FRM_LEN), .FRM_STATE(FRM_STATE), .GOOD_CNT(GOOD_CNT), .BAD_CNT(BAD_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  logic [31:0]      crc_tbl [256];
  logic [7:0]       tx_q [$];
  logic [8:0]       exp_b [$];
  logic [8:0]       got_b [$];
  logic [LEN_W+1:0] exp_e [$];
  logic [LEN_W+1:0] got_e [$];
  int exp_drop = 0;
  int got_drop = 0;
  int stray = 0;
  int exp_good = 0;
  int exp_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: records every emitted byte (with SOF), status and drop pulse.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (DOUT_VALID) got_b.push_back({SOF, DOUT});
      else if (SOF) stray++;
      if (EOF) got_e.push_back({CRC_OK, CRC_ERR, FRM_LEN});
      else if (CRC_OK || CRC_ERR) stray++;
      if (CRC_OK && CRC_ERR) stray++;
      if (DROPPED) got_drop++;
    end
  end

  // FCS over tx_q[first +: cnt], table driven, final complement applied.
  function automatic logic [31:0] fcs_of(input int first, input int cnt);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < cnt; i++) c = crc_tbl[c[7:0] ^ tx_q[first+i]] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic build_frame(input int npre, input logic [7:0] sfd, input int plen,
                             input bit rnd, input bit bad_fcs);
    logic [31:0] f;
    int base;
    tx_q.delete();
    for (int i = 0; i < npre; i++) tx_q.push_back(8'h55);
    tx_q.push_back(sfd);
    base = tx_q.size();
    for (int i = 0; i < plen; i++) tx_q.push_back(rnd ? 8'($urandom) : 8'(i + 1));
    f = fcs_of(base, plen);
    if (bad_fcs) f = f ^ 32'h0000_0100;
    for (int i = 0; i < 4; i++) tx_q.push_back(f[8*i +: 8]);
  endtask

  // Frame-level reference: decides outcome of the RX_DV run in tx_q.
  task automatic model_frame(input int er_idx);
    int n, p, m, k, d0, outs;
    bit drop, eof, ok;
    logic [31:0] f;
    n = tx_q.size();
    p = 0; drop = 0; eof = 0; ok = 0; outs = 0;
    if (n == 0) return;
    if (tx_q[0] != 8'h55) begin
      drop = 1;
    end else begin
      while (p < n && tx_q[p] == 8'h55) p++;
      if (er_idx >= 1 && er_idx <= p && er_idx < n) begin
        drop = 1;
      end else if (p < n) begin
        if (tx_q[p] != 8'hD5 || p < MIN_PRE) begin
          drop = 1;
        end else begin
          d0 = p + 1;
          m = n - d0;
          if (er_idx >= d0 && er_idx < n) begin
            k = er_idx - d0;
            outs = (k > 4) ? k - 4 : 0;
            drop = 1;
          end else if (m - 4 > MAX_LEN) begin
            outs = MAX_LEN;
            drop = 1;
          end else begin
            outs = (m > 4) ? m - 4 : 0;
            eof = 1;
            if (m >= 5) begin
              f = fcs_of(d0, m - 4);
              ok = ({tx_q[n-1], tx_q[n-2], tx_q[n-3], tx_q[n-4]} == f);
            end
          end
          if (outs > MAX_LEN) outs = MAX_LEN;
          for (int i = 0; i < outs; i++) exp_b.push_back({(i == 0), tx_q[d0+i]});
        end
      end
    end
    if (drop) begin exp_drop++; exp_bad++; end
    if (eof) begin
      exp_e.push_back({ok, !ok, LEN_W'(outs)});
      if (ok) exp_good++; else exp_bad++;
    end
  endtask

  task automatic send_burst(input int er_idx, input int gap, input int ncut, input bit chk_drop);
    int lim;
    lim = (ncut >= 0) ? ncut : tx_q.size();
    for (int i = 0; i < lim; i++) begin
      @(negedge CLK);
      if (chk_drop && er_idx >= 0 && i > er_idx) check_eq("drop_state", 32'(FRM_STATE), 32'd4);
      RX_DV = 1'b1;
      RXD = tx_q[i];
      RX_ER = (i == er_idx);
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge CLK);
      RX_DV = 1'b0;
      RX_ER = 1'b0;
      RXD = 8'($urandom);
    end
  endtask

  task automatic run_frame(input int er_idx, input int gap, input bit chk_drop);
    model_frame(er_idx);
    send_burst(er_idx, gap, -1, chk_drop);
  endtask

  task automatic clear_all();
    exp_b.delete(); got_b.delete(); exp_e.delete(); got_e.delete();
    exp_drop = 0; got_drop = 0; stray = 0;
  endtask

  task automatic check_all(input string tag);
    int nb, ne;
    repeat (6) begin
      @(negedge CLK);
      RX_DV = 1'b0;
      RX_ER = 1'b0;
    end
    check_eq({tag, ".nbytes"}, 32'(got_b.size()), 32'(exp_b.size()));
    nb = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
    for (int i = 0; i < nb; i++) check_eq($sformatf("%s.byte%0d", tag, i), 32'(got_b[i]), 32'(exp_b[i]));
    check_eq({tag, ".neof"}, 32'(got_e.size()), 32'(exp_e.size()));
    ne = (got_e.size() < exp_e.size()) ? got_e.size() : exp_e.size();
    for (int i = 0; i < ne; i++) check_eq($sformatf("%s.eof%0d", tag, i), 32'(got_e[i]), 32'(exp_e[i]));
    check_eq({tag, ".dropped"}, 32'(got_drop), 32'(exp_drop));
    check_eq({tag, ".stray"}, 32'(stray), 32'd0);
    check_eq({tag, ".idle"}, 32'(FRM_STATE), 32'd0);
`ifdef RX_STATS_EN
    check_eq({tag, ".good_cnt"}, 32'(GOOD_CNT), 32'(exp_good));
    check_eq({tag, ".bad_cnt"}, 32'(BAD_CNT), 32'(exp_bad));
`else
    check_eq({tag, ".good_cnt"}, 32'(GOOD_CNT), 32'd0);
    check_eq({tag, ".bad_cnt"}, 32'(BAD_CNT), 32'd0);
`endif
    clear_all();
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, ".state"}, 32'(FRM_STATE), 32'd0);
    check_eq({tag, ".dout"}, 32'(DOUT), 32'd0);
    check_eq({tag, ".valid"}, 32'(DOUT_VALID), 32'd0);
    check_eq({tag, ".pulses"}, 32'({SOF, EOF, CRC_OK, CRC_ERR, DROPPED}), 32'd0);
    check_eq({tag, ".frm_len"}, 32'(FRM_LEN), 32'd0);
    check_eq({tag, ".cnts"}, {GOOD_CNT, BAD_CNT}, 32'd0);
  endtask

  initial begin
    for (int n = 0; n < 256; n++) begin
      logic [31:0] r;
      r = 32'(n);
      for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      crc_tbl[n] = r;
    end

    repeat (2) @(negedge CLK);
    check_zero("reset");
    RST_N = 1'b1;
    @(negedge CLK);

    // Two back-to-back 16-byte frames, then an oversize frame.
    build_frame(7, 8'hD5, 16, 1'b1, 1'b0); run_frame(-1, 1, 1'b0);
    build_frame(7, 8'hD5, 16, 1'b1, 1'b0); run_frame(-1, 1, 1'b0);
    build_frame(7, 8'hD5, 1519, 1'b0, 1'b0); run_frame(-1, 1, 1'b0);
    check_all("b2b_oversize");

    build_frame(7, 8'hD5, 64, 1'b0, 1'b0); run_frame(-1, 2, 1'b0);
    check_all("good64");

    build_frame(7, 8'hD5, 64, 1'b0, 1'b0); tx_q[39] = 8'hDF; run_frame(-1, 2, 1'b0);
    check_all("bad_crc");

    build_frame(7, 8'hD5, 64, 1'b0, 1'b0); run_frame(17, 2, 1'b1);
    check_all("rx_er");

    build_frame(1, 8'hD5, 8, 1'b1, 1'b0); run_frame(-1, 2, 1'b0);
    check_all("short_pre");

    tx_q.delete();
    tx_q.push_back(8'h55); tx_q.push_back(8'h55); tx_q.push_back(8'hD5);
    tx_q.push_back(8'hAA); tx_q.push_back(8'hBB);
    run_frame(-1, 2, 1'b0);
    check_all("runt");

    tx_q.delete();
    tx_q.push_back(8'h12); tx_q.push_back(8'h55); tx_q.push_back(8'h34);
    run_frame(-1, 2, 1'b0);
    check_all("garbage");

    build_frame(2, 8'hD5, MAX_LEN, 1'b1, 1'b0); run_frame(-1, 1, 1'b0);
    check_all("max_len");

    for (int r = 0; r < 25; r++) begin
      int npre, plen, er, gap;
      logic [7:0] sfd;
      npre = $urandom_range(1, 9);
      sfd = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hD5;
      plen = $urandom_range(0, 60);
      build_frame(npre, sfd, plen, 1'b1, ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 9) == 0) begin
        int keep;
        keep = $urandom_range(1, tx_q.size());
        while (tx_q.size() > keep) void'(tx_q.pop_back());
      end
      er = ($urandom_range(0, 5) == 0 && tx_q.size() > 1) ? $urandom_range(1, tx_q.size() - 1) : -1;
      gap = $urandom_range(1, 3);
      run_frame(er, gap, 1'b0);
    end
    check_all("random");

    // Reset pulse in the middle of a frame's payload.
    build_frame(7, 8'hD5, 64, 1'b0, 1'b0);
    send_burst(-1, 0, 30, 1'b0);
    @(negedge CLK);
    check_eq("pre_rst.valid", 32'(DOUT_VALID), 32'd1);
    check_eq("pre_rst.state", 32'(FRM_STATE), 32'd2);
    RST_N = 1'b0;
    RX_DV = 1'b0;
    #1;
    check_zero("mid_rst");
    @(negedge CLK);
    RST_N = 1'b1;
    clear_all();
    exp_good = 0;
    exp_bad = 0;
    build_frame(7, 8'hD5, 64, 1'b0, 1'b0); run_frame(-1, 2, 1'b0);
    check_all("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
